// File: rtl/seven_seg_scanner_pkg.sv
// Segment glyph tables and BCD decode helper shared by the scanner and its decoder.
// Patterns are active-high {a,b,c,d,e,f,g} with a in bit 6.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h01;

  localparam logic [0:9][6:0] SEG_DIGIT = {
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
    7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
  };

  // Codes 10-15 are not valid BCD; show a dash so a bad counter is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    if (nib > 4'd9) return SEG_DASH;
    return SEG_DIGIT[nib];
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display bus: digit data/load from the counter side, multiplexed drive to the board.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] bcd;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;

  modport master (output bcd, dp, load, input seg, dp_out, an, digit_idx);
  modport slave  (input bcd, dp, load, output seg, dp_out, an, digit_idx);
endinterface

// File: rtl/seven_seg_scanner_decode.sv
// Nibble to active-high segments; a blanked slot lights nothing.
module seven_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);
  // Pure lookup; polarity is applied by the caller's output register.
  always_comb begin
    seg = blank ? SEG_BLANK : bcd_to_seg(nibble);
  end
endmodule

// File: rtl/seven_seg_scanner.sv
// Shadow-captures packed BCD digits and scans them onto one shared 7-segment bus.
// All board-facing outputs come straight from flops so the scan is glitch-free.
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 4,
  parameter int BLANK_LEADING = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input logic              clk,
  input logic              rst,
  seven_seg_scanner_if.slave disp
);
  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic POL   = (ACTIVE_LOW != 0);

  logic [NUM_DIGITS-1:0][3:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [PRE_W-1:0]           pre;
  logic [IDX_W-1:0]           sel;
  logic [NUM_DIGITS-1:0]      blank;
  logic [3:0]                 cur_nib;
  logic                       cur_blank;
  logic                       cur_dp;
  logic [NUM_DIGITS-1:0]      cur_an;
  logic [6:0]                 cur_seg;

  // Shadow capture: the display only ever reads this copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_bcd <= '0;
      shadow_dp  <= '0;
    end else if (disp.load) begin
      shadow_bcd <= disp.bcd;
      shadow_dp  <= disp.dp;
    end
  end

  // Prescaler and scan index; the index steps once per REFRESH_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      sel <= '0;
    end else if (pre == PRE_W'(REFRESH_DIV - 1)) begin
      pre <= '0;
      sel <= (sel == IDX_W'(NUM_DIGITS - 1)) ? '0 : sel + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Leading-zero mask: walk from the top digit down until something is lit.
  always_comb begin
    logic lit;
    lit   = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lit      = lit | (shadow_bcd[i] != 4'd0) | shadow_dp[i];
      blank[i] = (BLANK_LEADING != 0) && (i != 0) && !lit;
    end
  end

  // Pick the currently scanned digit and build its one-hot anode (active-high).
  always_comb begin
    cur_nib   = shadow_bcd[sel];
    cur_blank = blank[sel];
    cur_dp    = shadow_dp[sel] & ~cur_blank;
    cur_an    = '0;
    if (!cur_blank) cur_an[sel] = 1'b1;
  end

  seven_seg_decode u_dec (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .seg    (cur_seg)
  );

  // Output register: polarity applied here; a load coinciding with an index
  // step is naturally seen one edge later because both feed this flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp.seg       <= {7{POL}};
      disp.dp_out    <= POL;
      disp.an        <= {NUM_DIGITS{POL}};
      disp.digit_idx <= '0;
    end else begin
      disp.seg       <= cur_seg ^ {7{POL}};
      disp.dp_out    <= cur_dp ^ POL;
      disp.an        <= cur_an ^ {NUM_DIGITS{POL}};
      disp.digit_idx <= sel;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a timing/decode model pushes the
// expected display for every edge, a negedge monitor pops and compares.
module tb_seven_seg_scanner;
  localparam int N = 4;
  localparam int R = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t        q[$];
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_dp  = '0;
  int          mcyc  = 0;

  always #5 clk = ~clk;

  seven_seg_scanner_if #(.NUM_DIGITS(N)) disp ();

  seven_seg_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_LEADING(1), .ACTIVE_LOW(1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (disp)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Active-high glyphs as drawn on the board.
  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  // Display expected after the edge that is the k-th since reset release.
  function automatic exp_t model_out(input int k, input logic [15:0] b, input logic [3:0] d);
    exp_t e;
    int   i;
    int   nib;
    bit   blank;
    i     = (k / R) % N;
    nib   = int'((b >> (4 * i)) & 16'hF);
    blank = (i > 0) && ((b >> (4 * i)) == 16'h0) && ((d >> i) == 4'h0);
    e.idx = 2'(i);
    if (blank) begin
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.an  = 4'hF;
    end else begin
      e.seg = ~glyph(nib);
      e.dp  = ~d[i];
      e.an  = ~(4'b0001 << i);
    end
    return e;
  endfunction

  // Reference model: sees the pre-edge shadow, then applies the load.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_bcd = '0;
        m_dp  = '0;
        mcyc  = 0;
        q.delete();
      end else begin
        q.push_back(model_out(mcyc, m_bcd, m_dp));
        if (disp.load) begin
          m_bcd = disp.bcd;
          m_dp  = disp.dp;
        end
        mcyc++;
      end
    end
  end

  // Monitor: compare DUT display against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        chk("seg", 32'(disp.seg), 32'(e.seg));
        chk("dp_out", 32'(disp.dp_out), 32'(e.dp));
        chk("an", 32'(disp.an), 32'(e.an));
        chk("digit_idx", 32'(disp.digit_idx), 32'(e.idx));
      end
    end
  end

  task automatic load_val(input logic [15:0] b, input logic [3:0] d);
    disp.bcd  = b;
    disp.dp   = d;
    disp.load = 1'b1;
    @(negedge clk);
    disp.load = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"}, 32'(disp.seg), 32'h7F);
    chk({tag, "_dp_out"}, 32'(disp.dp_out), 32'h1);
    chk({tag, "_an"}, 32'(disp.an), 32'hF);
    chk({tag, "_idx"}, 32'(disp.digit_idx), 32'h0);
  endtask

  initial begin
    int guard;
    int cnt;
    disp.bcd  = '0;
    disp.dp   = '0;
    disp.load = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Directed patterns, each held over at least two full scans.
    load_val(16'h1234, 4'b0000); repeat (40) @(negedge clk);
    load_val(16'h0070, 4'b0000); repeat (36) @(negedge clk);
    load_val(16'h0000, 4'b0100); repeat (36) @(negedge clk);
    load_val(16'h00A5, 4'b0000); repeat (36) @(negedge clk);

    // Load on the 0->1 index-advance edge.
    load_val(16'h1234, 4'b0000); repeat (20) @(negedge clk);
    guard = 0;
    while ((mcyc % 16) != 3 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk("advance_sync", 32'(guard < 64), 32'h1);
    load_val(16'h9999, 4'b0000);
    chk("old_slot_seg", 32'(disp.seg), 32'h4C);
    chk("old_slot_an", 32'(disp.an), 32'hE);
    @(negedge clk);
    chk("new_slot_seg", 32'(disp.seg), 32'h04);
    chk("new_slot_an", 32'(disp.an), 32'hD);
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of a slot.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midscan");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Four chained decade counters feeding the display.
    cnt = 9990;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 1) == 1) cnt = (cnt + 1) % 10000;
      disp.bcd  = {4'(cnt / 1000 % 10), 4'(cnt / 100 % 10), 4'(cnt / 10 % 10), 4'(cnt % 10)};
      disp.dp   = '0;
      disp.load = ($urandom_range(0, 30) == 0);
      @(negedge clk);
    end

    // Random codes, including invalid nibbles and sparse decimal points.
    for (int c = 0; c < 1000; c++) begin
      disp.bcd  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      disp.dp   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      disp.load = ($urandom_range(0, 12) == 0);
      @(negedge clk);
    end
    disp.load = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
